// File: rtl/clz_iter_unit_pkg.sv
// rtl/clz_iter_unit_pkg.sv - shared types and helpers for the iterative CLZ/CLO unit
package clz_iter_unit_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    localparam logic CLZ_MODE = 1'b0;
    localparam logic CLO_MODE = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/clz_iter_unit_chunk.sv
// rtl/clz_iter_unit_chunk.sv - combinational leading-zero priority encoder for one chunk
module clz_chunk #(
    parameter int CHUNK = 8,
    parameter int ZW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] in_i,
    output logic [ZW-1:0]    zcnt_o
);

    // Scanning upward lets the highest set bit overwrite lower ones.
    always_comb begin
        zcnt_o = ZW'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (in_i[i]) begin
                zcnt_o = ZW'(CHUNK - 1 - i);
            end
        end
    end

endmodule

// File: rtl/clz_iter_unit.sv
// rtl/clz_iter_unit.sv - multi-cycle count-leading-zeros/ones unit with start/busy/done handshake
module clz_iter_unit
    import clz_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_clo,
    input  logic             abort,
    input  logic [WIDTH-1:0] rs_value,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam int ZW     = $clog2(CHUNK + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0 || (CHUNK & (CHUNK - 1)) != 0) begin : g_bad_param
        $error("clz_iter_unit: WIDTH must be a multiple of CHUNK and CHUNK a power of two");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic [ZW-1:0]    zcnt;

    clz_chunk #(.CHUNK(CHUNK), .ZW(ZW)) u_chunk (
        .in_i   (shreg_q[WIDTH-1 -: CHUNK]),
        .zcnt_o (zcnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        cnt_sum  = cnt_q + CNT_W'(zcnt);
        case (state_q)
            ST_IDLE: begin
                // CLO is CLZ of the inverted operand, so only one scan path exists.
                if (start && !abort) begin
                    shreg_d = (mode_clo == CLO_MODE) ? ~rs_value : rs_value;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (zcnt == ZW'(CHUNK) && idx_q != LAST) begin
                    cnt_d   = cnt_q + CNT_W'(CHUNK);
                    shreg_d = shreg_q << CHUNK;
                    idx_d   = idx_q + IDX_W'(1);
                end else begin
                    result_d = WIDTH'(cnt_sum);
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    assign busy   = (state_q == ST_SCAN);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_clz_iter_unit.sv
// tb/tb_clz_iter_unit.sv - self-checking bench for clz_iter_unit against a behavioural model
module tb_clz_iter_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_sw_n, start, mode_clo, abort, chk_en;
    logic [31:0] rs_value, result;
    logic        busy, done;
    int          total = 0;
    int          bad = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int ref_lz(input logic [63:0] v, input int w);
        int n;
        n = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic int ref_k(input int lz, input int w, input int c);
        int k;
        k = lz / c + 1;
        if (k > w / c) k = w / c;
        return k;
    endfunction

    clz_iter_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode_clo (mode_clo),
        .abort    (abort),
        .rs_value (rs_value),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Cycle model: an accepted op keeps the unit busy for k cycles, then publishes its count.
    int          m_left, m_pend;
    logic        m_done;
    logic [31:0] m_res;
    logic        m_busy;
    assign m_busy = (m_left > 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_pend <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                if (abort) begin
                    m_left <= 0;
                end else begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_done <= 1'b1;
                        m_res  <= 32'(m_pend);
                    end
                end
            end else if (start && !abort) begin
                m_pend <= ref_lz(mode_clo ? ~rs_value : rs_value, 32);
                m_left <= ref_k(ref_lz(mode_clo ? ~rs_value : rs_value, 32), 32, 8);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("cyc_busy", busy, m_busy);
            check("cyc_done", done, m_done);
            check("cyc_result", result, m_res);
        end
    end

    // Width/chunk sweep, each instance checked for result and latency.
    localparam int SW[4] = '{32, 32, 32, 64};
    localparam int SC[4] = '{1, 4, 32, 8};

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W = SW[g];
        localparam int C = SC[g];
        logic         s_start, s_clo, s_busy, s_done, s_fin;
        logic [W-1:0] s_rs, s_res;

        clz_iter_unit #(.WIDTH(W), .CHUNK(C)) u_sw (
            .clk      (clk),
            .rst_n    (rst_sw_n),
            .start    (s_start),
            .mode_clo (s_clo),
            .abort    (1'b0),
            .rs_value (s_rs),
            .busy     (s_busy),
            .done     (s_done),
            .result   (s_res)
        );

        initial begin
            logic [63:0] v;
            int lz, c;
            s_fin = 1'b0;
            s_start = 1'b0;
            s_clo = 1'b0;
            s_rs = '0;
            wait (rst_sw_n === 1'b1);
            @(negedge clk);
            for (int n = 0; n < 40; n++) begin
                v = {$urandom, $urandom} >> $urandom_range(0, 64);
                s_clo = 1'($urandom_range(0, 1));
                if (s_clo) v = ~v;
                if (n == 0) begin v = '0; s_clo = 1'b0; end
                if (n == 1) begin v = '1; s_clo = 1'b1; end
                s_rs = W'(v);
                s_start = 1'b1;
                @(negedge clk);
                s_start = 1'b0;
                check($sformatf("sw%0d_busy", g), s_busy, 1);
                c = 0;
                while (!s_done && c < 100) begin
                    @(negedge clk);
                    c++;
                end
                lz = ref_lz(s_clo ? ~v : v, W);
                check($sformatf("sw%0d_result", g), s_res, lz);
                check($sformatf("sw%0d_k", g), c, ref_k(lz, W, C));
            end
            s_fin = 1'b1;
        end
    end

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic op(input logic [31:0] v, input logic clo, input int exp_res, input int exp_k,
                      input string nm);
        int c, nb;
        logic [31:0] eff;
        eff = clo ? ~v : v;
        check({nm, "_model_res"}, ref_lz(eff, 32), exp_res);
        check({nm, "_model_k"}, ref_k(ref_lz(eff, 32), 32, 8), exp_k);
        @(negedge clk);
        start = 1'b1;
        rs_value = v;
        mode_clo = clo;
        @(negedge clk);
        start = 1'b0;
        nb = busy ? 1 : 0;
        c = 0;
        while (!done && c < 100) begin
            @(negedge clk);
            c++;
            if (busy) nb++;
        end
        check({nm, "_result"}, result, exp_res);
        check({nm, "_k"}, c, exp_k);
        check({nm, "_busy_cycles"}, nb, exp_k);
    endtask

    initial begin
        int c;
        logic seen;
        rst_n = 1'b0;
        rst_sw_n = 1'b0;
        start = 1'b0;
        mode_clo = 1'b0;
        abort = 1'b0;
        rs_value = '0;
        chk_en = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        rst_n = 1'b1;
        rst_sw_n = 1'b1;
        chk_en = 1'b1;

        op(32'h8000_0000, 1'b0, 0, 1, "clz_msb");
        op(32'h00FF_0000, 1'b0, 8, 2, "clz_ff0000");
        op(32'h0000_0001, 1'b0, 31, 4, "clz_one");
        op(32'h0000_0000, 1'b0, 32, 4, "clz_zero");
        op(32'hFFFF_FFFF, 1'b1, 32, 4, "clo_ones");
        op(32'hF0F0_0000, 1'b1, 4, 1, "clo_f0f0");

        // Asynchronous reset mid-scan clears outputs without waiting for a clock.
        @(negedge clk);
        start = 1'b1;
        rs_value = 32'h0;
        mode_clo = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(32'h0001_0000, 1'b0, 15, 2, "after_rst");

        // Start held through busy with a moving operand; then accepted again in the done cycle.
        @(negedge clk);
        start = 1'b1;
        mode_clo = 1'b0;
        rs_value = 32'h0000_0001;
        @(negedge clk);
        c = 0;
        while (!done && c < 100) begin
            rs_value = $urandom;
            @(negedge clk);
            c++;
        end
        check("held_start_result", result, 31);
        check("held_start_k", c, 4);
        rs_value = 32'h8000_0000;
        @(negedge clk);
        check("start_in_done_busy", busy, 1);
        start = 1'b0;
        wait_done(c);
        check("start_in_done_result", result, 0);

        // Abort in the second scan cycle leaves the previous result in place.
        op(32'h00FF_0000, 1'b0, 8, 2, "pre_abort");
        @(negedge clk);
        start = 1'b1;
        rs_value = 32'h0000_00FF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        seen = done;
        repeat (6) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        check("abort_result_kept", result, 8);
        start = 1'b1;
        abort = 1'b1;
        rs_value = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle", busy, 0);

        // Random traffic: arbitrary start/abort/operand changes every cycle against the model.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            abort = ($urandom_range(0, 11) == 0);
            mode_clo = 1'($urandom_range(0, 1));
            rs_value = $urandom >> $urandom_range(0, 32);
            if (mode_clo) rs_value = ~rs_value;
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (10) @(negedge clk);

        c = 0;
        while (!(g_sw[0].s_fin && g_sw[1].s_fin && g_sw[2].s_fin && g_sw[3].s_fin) && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check("sweep_finished",
              {g_sw[0].s_fin, g_sw[1].s_fin, g_sw[2].s_fin, g_sw[3].s_fin}, 4'hF);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
